// File: rtl/peak_frame_feeder.sv
// Buffers a raw signed sample stream and releases only complete K-sample frames,
// pausing under downstream stop. Optional macro ABS_FOLD_EN emits sample magnitudes.
module peak_frame_feeder #(
   parameter int N     = 16,
   parameter int K     = 42,
   parameter int DEPTH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic [N-1:0] s_data,
   output logic         s_ready,
   input  logic         stop,
   output logic         ready,
   output logic [N-1:0] out_data,
   output logic         frame_start,
   output logic         frame_last,
   output logic         frame_done,
   output logic [15:0]  frame_cnt,
   output logic         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   K_C      = (AW+1)'(K);
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
   logic [IW-1:0] idx_q;
   logic [N-1:0]  out_data_q;
   logic          ready_q, frame_start_q, frame_last_q, overflow_q;
   logic [15:0]   frame_cnt_q;
   logic          push, pop, frame_avail;

   function automatic logic [N-1:0] fold_sample(input logic [N-1:0] x);
`ifdef ABS_FOLD_EN
      logic [N-1:0] mag;
      mag = x;
      // The most negative value has no positive twin, so it saturates.
      if (x[N-1]) begin
         if (x == {1'b1, {(N-1){1'b0}}}) mag = {1'b0, {(N-1){1'b1}}};
         else                            mag = ~x + 1'b1;
      end
      return mag;
`else
      return x;
`endif
   endfunction

   // s_ready is held low while reset is asserted, otherwise only the registered count matters.
   assign s_ready     = !rst && (count_q != DEPTH_C);
   assign push        = s_valid && s_ready;
   assign frame_avail = (count_q >= K_C);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (s_valid && !s_ready) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A frame only begins once K samples are buffered, so it can never starve mid-frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_avail) state_d = SEND;
         SEND:    if (pop && idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = frame_avail ? SEND : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         SEND:    pop = !stop;
         DONE:    frame_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q         <= '0;
         out_data_q    <= '0;
         ready_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_last_q  <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         if (state_q != SEND) idx_q <= '0;
         else if (pop)        idx_q <= idx_q + 1'b1;
         // Markers travel with the data word; out_data holds while stopped.
         if (pop) begin
            out_data_q    <= fold_sample(mem_q[rd_ptr_q[AW-1:0]]);
            ready_q       <= 1'b1;
            frame_start_q <= (idx_q == '0);
            frame_last_q  <= (idx_q == LAST_IDX);
         end else begin
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
         end
         if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign ready       = ready_q;
   assign out_data    = out_data_q;
   assign frame_start = frame_start_q;
   assign frame_last  = frame_last_q;
   assign frame_cnt   = frame_cnt_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_peak_frame_feeder.sv
// Directed self-checking bench for peak_frame_feeder: frames, partial hold, stop,
// overflow, back-to-back frames, mid-frame reset and the magnitude fold.
module tb_peak_frame_feeder;

   localparam int N     = 16;
   localparam int K     = 42;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic [N-1:0]  s_data;
   logic          s_ready;
   logic          stop;
   logic          ready;
   logic [N-1:0]  out_data;
   logic          frame_start;
   logic          frame_last;
   logic          frame_done;
   logic [15:0]   frame_cnt;
   logic          overflow;

   int checks = 0;
   int passes = 0;

   peak_frame_feeder #(.N(N), .K(K), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .stop(stop),
      .ready(ready),
      .out_data(out_data),
      .frame_start(frame_start),
      .frame_last(frame_last),
      .frame_done(frame_done),
      .frame_cnt(frame_cnt),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic apply_reset(input logic hold_stop);
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      stop    = hold_stop;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_seq(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = N'(first + i);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      stop    = 1'b0;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) $display("[TB] FAIL reset_s_ready: got %0b expected 0", s_ready);
      else passes++;
      checks++;
      if ({ready, frame_start, frame_last, frame_done, overflow} !== 5'b0 || out_data !== '0 || frame_cnt !== 16'd0)
         $display("[TB] FAIL reset_outputs: got ready=%0b start=%0b last=%0b done=%0b ovf=%0b data=%0d cnt=%0d expected all 0",
                  ready, frame_start, frame_last, frame_done, overflow, out_data, frame_cnt);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || ready !== 1'b0)
         $display("[TB] FAIL post_reset: got s_ready=%0b ready=%0b expected s_ready=1 ready=0", s_ready, ready);
      else passes++;
   endtask

   task automatic test_basic_frame();
      bit ok;
      int pulses;
      push_seq(K, 1);
      wait_ready(6, ok);
      checks++;
      if (!ok) $display("[TB] FAIL basic_start: got ready=0 expected ready within 6 cycles");
      else passes++;
      for (int k = 0; k < K; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (ready !== 1'b1 || out_data !== N'(k + 1) || frame_start !== (k == 0) || frame_last !== (k == K - 1))
            $display("[TB] FAIL basic_sample%0d: got ready=%0b data=%0d start=%0b last=%0b expected ready=1 data=%0d start=%0b last=%0b",
                     k, ready, out_data, frame_start, frame_last, k + 1, (k == 0), (k == K - 1));
         else passes++;
      end
      pulses = int'(frame_done);
      repeat (2) begin
         @(negedge clk);
         pulses += int'(frame_done);
      end
      checks++;
      if (pulses != 1) $display("[TB] FAIL basic_done_pulse: got %0d pulses expected 1", pulses);
      else passes++;
      checks++;
      if (frame_cnt !== 16'd1) $display("[TB] FAIL basic_frame_cnt: got %0d expected 1", frame_cnt);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b0) $display("[TB] FAIL basic_idle: got ready=%0b expected 0", ready);
      else passes++;
   endtask

   task automatic test_partial_hold();
      bit ok;
      bit seen;
      push_seq(K - 1, 101);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ready === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) $display("[TB] FAIL partial_held: got ready=1 with %0d samples expected 0", K - 1);
      else passes++;
      push_seq(1, 100 + K);
      wait_ready(2, ok);
      checks++;
      if (!ok) $display("[TB] FAIL partial_start: got ready=0 expected ready within 2 cycles");
      else passes++;
      for (int k = 0; k < K; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (ready !== 1'b1 || out_data !== N'(101 + k))
            $display("[TB] FAIL partial_sample%0d: got ready=%0b data=%0d expected ready=1 data=%0d", k, ready, out_data, 101 + k);
         else passes++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (frame_cnt !== 16'd2) $display("[TB] FAIL partial_frame_cnt: got %0d expected 2", frame_cnt);
      else passes++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int pulses;
      push_seq(K, 201);
      wait_ready(6, ok);
      checks++;
      if (!ok) $display("[TB] FAIL bp_start: got ready=0 expected ready within 6 cycles");
      else passes++;
      for (int k = 1; k <= K; k++) begin
         if (k > 1) @(negedge clk);
         checks++;
         if (ready !== 1'b1 || out_data !== N'(200 + k) || frame_last !== (k == K))
            $display("[TB] FAIL bp_sample%0d: got ready=%0b data=%0d last=%0b expected ready=1 data=%0d last=%0b",
                     k, ready, out_data, frame_last, 200 + k, (k == K));
         else passes++;
         if (k == 10) begin
            stop = 1'b1;
            for (int h = 0; h < 5; h++) begin
               @(negedge clk);
               checks++;
               if (ready !== 1'b0 || out_data !== N'(210))
                  $display("[TB] FAIL bp_hold%0d: got ready=%0b data=%0d expected ready=0 data=210", h, ready, out_data);
               else passes++;
            end
            stop = 1'b0;
         end
      end
      pulses = int'(frame_done);
      repeat (2) begin
         @(negedge clk);
         pulses += int'(frame_done);
      end
      checks++;
      if (pulses != 1 || frame_cnt !== 16'd3)
         $display("[TB] FAIL bp_done: got pulses=%0d cnt=%0d expected pulses=1 cnt=3", pulses, frame_cnt);
      else passes++;
   endtask

   task automatic test_overflow();
      bit ok;
      apply_reset(1'b1);
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (i == 63) begin
            checks++;
            if (s_ready !== 1'b1) $display("[TB] FAIL ovf_ready_63: got s_ready=%0b expected 1", s_ready);
            else passes++;
         end
         if (i == 64) begin
            checks++;
            if (s_ready !== 1'b0 || overflow !== 1'b0)
               $display("[TB] FAIL ovf_full_64: got s_ready=%0b overflow=%0b expected s_ready=0 overflow=0", s_ready, overflow);
            else passes++;
         end
         s_valid = 1'b1;
         s_data  = N'(i + 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || s_ready !== 1'b0 || ready !== 1'b0)
         $display("[TB] FAIL ovf_state: got overflow=%0b s_ready=%0b ready=%0b expected 1 0 0", overflow, s_ready, ready);
      else passes++;
      stop = 1'b0;
      wait_ready(4, ok);
      checks++;
      if (!ok) $display("[TB] FAIL ovf_start: got ready=0 expected ready within 4 cycles");
      else passes++;
      for (int k = 0; k < K; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (ready !== 1'b1 || out_data !== N'(k + 1))
            $display("[TB] FAIL ovf_sample%0d: got ready=%0b data=%0d expected ready=1 data=%0d", k, ready, out_data, k + 1);
         else passes++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (overflow !== 1'b1 || frame_cnt !== 16'd1 || ready !== 1'b0)
         $display("[TB] FAIL ovf_after: got overflow=%0b cnt=%0d ready=%0b expected 1 1 0", overflow, frame_cnt, ready);
      else passes++;
   endtask

   task automatic test_back_to_back_reset();
      bit ok;
      bit seen;
      int pulses;
      apply_reset(1'b0);
      fork
         push_seq(2 * K, 1);
         begin
            wait_ready(100, ok);
            checks++;
            if (!ok) $display("[TB] FAIL b2b_start: got ready=0 expected ready within 100 cycles");
            else passes++;
            for (int k = 0; k < 2 * K; k++) begin
               if (k > 0) @(negedge clk);
               if (k == K) begin
                  checks++;
                  if (ready !== 1'b0 || frame_cnt !== 16'd1)
                     $display("[TB] FAIL b2b_gap: got ready=%0b cnt=%0d expected ready=0 cnt=1", ready, frame_cnt);
                  else passes++;
                  @(negedge clk);
               end
               checks++;
               if (ready !== 1'b1 || out_data !== N'(k + 1) || frame_start !== (k % K == 0) || frame_last !== (k % K == K - 1))
                  $display("[TB] FAIL b2b_sample%0d: got ready=%0b data=%0d start=%0b last=%0b expected ready=1 data=%0d start=%0b last=%0b",
                           k, ready, out_data, frame_start, frame_last, k + 1, (k % K == 0), (k % K == K - 1));
               else passes++;
            end
         end
      join
      pulses = int'(frame_done);
      repeat (2) begin
         @(negedge clk);
         pulses += int'(frame_done);
      end
      checks++;
      if (pulses != 1 || frame_cnt !== 16'd2)
         $display("[TB] FAIL b2b_done: got pulses=%0d cnt=%0d expected pulses=1 cnt=2", pulses, frame_cnt);
      else passes++;
      push_seq(K, 301);
      wait_ready(6, ok);
      checks++;
      if (!ok) $display("[TB] FAIL rst3_start: got ready=0 expected ready within 6 cycles");
      else passes++;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
      end
      checks++;
      if (ready !== 1'b1 || out_data !== N'(321))
         $display("[TB] FAIL rst3_idx20: got ready=%0b data=%0d expected ready=1 data=321", ready, out_data);
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if ({s_ready, ready, frame_start, frame_last, frame_done, overflow} !== 6'b0 || out_data !== '0 || frame_cnt !== 16'd0)
         $display("[TB] FAIL rst3_outputs: got s_ready=%0b ready=%0b start=%0b last=%0b done=%0b ovf=%0b data=%0d cnt=%0d expected all 0",
                  s_ready, ready, frame_start, frame_last, frame_done, overflow, out_data, frame_cnt);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || ready !== 1'b0 || frame_done !== 1'b0)
         $display("[TB] FAIL rst3_release: got s_ready=%0b ready=%0b done=%0b expected 1 0 0", s_ready, ready, frame_done);
      else passes++;
      // Leftover samples plus these 21 would make a full frame if the FIFO were not emptied.
      push_seq(K / 2, 401);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ready === 1'b1 || frame_done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) $display("[TB] FAIL rst3_fifo_empty: got ready/done activity expected none");
      else passes++;
   endtask

   task automatic test_abs_fold();
      bit ok;
      logic [N-1:0] vec [K];
      logic [N-1:0] expv [K];
      for (int k = 0; k < K; k++) vec[k] = N'(500 + k);
      vec[5] = N'(-5);
      vec[6] = 16'h8000;
      vec[7] = N'(7);
      for (int k = 0; k < K; k++) expv[k] = vec[k];
`ifdef ABS_FOLD_EN
      expv[5] = N'(5);
      expv[6] = 16'h7FFF;
`endif
      apply_reset(1'b0);
      for (int k = 0; k < K; k++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = vec[k];
      end
      @(negedge clk);
      s_valid = 1'b0;
      wait_ready(6, ok);
      checks++;
      if (!ok) $display("[TB] FAIL abs_start: got ready=0 expected ready within 6 cycles");
      else passes++;
      for (int k = 0; k < K; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (ready !== 1'b1 || out_data !== expv[k])
            $display("[TB] FAIL abs_sample%0d: got ready=%0b data=%h expected ready=1 data=%h", k, ready, out_data, expv[k]);
         else passes++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (frame_cnt !== 16'd1) $display("[TB] FAIL abs_frame_cnt: got %0d expected 1", frame_cnt);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_partial_hold();
      test_backpressure();
      test_overflow();
      test_back_to_back_reset();
      test_abs_fold();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
